// File: rtl/buff_pkg.sv
// rtl/buff_pkg.sv - shared width and circular-index helpers for buffer blocks
package buff_pkg;

  // Index width that stays >= 1 even when a dimension collapses to a single entry
  function automatic int bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  // Operands are each < n, so one subtraction is enough for non-power-of-two depths
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction

endpackage

// File: rtl/shift.sv
// rtl/shift.sv - fixed-depth register delay line with async reset; depth 0 is a wire
module shift #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  generate
    if (DELAY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout_o = din_i;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DELAY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= din_i;
          for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout_o = stage_q[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/multi_fifo_buff.sv
// rtl/multi_fifo_buff.sv - NUMFIFO circular FIFOs sharing one data memory, with
// overflow/underflow rejection, per-FIFO flush and status, and a delayed pop-valid strobe.
module multi_fifo_buff
  import buff_pkg::*;
#(
  parameter int  NUMELEM   = 4,
  parameter int  BITDATA   = 4,
  parameter int  NUMFIFO   = 8,
  parameter int  DAT_DELAY = 1,
  localparam int BITFIFO   = bits(NUMFIFO)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               push,
  input  logic [BITFIFO-1:0] pu_prt,
  input  logic [BITDATA-1:0] pu_din,
  input  logic               pop,
  input  logic [BITFIFO-1:0] po_prt,
  input  logic               flush,
  input  logic [BITFIFO-1:0] fl_prt,
  output logic               po_vld,
  output logic [BITDATA-1:0] po_dout,
  output logic               pu_err,
  output logic               po_err,
  output logic [NUMFIFO-1:0] empty,
  output logic [NUMFIFO-1:0] full
);

  localparam int BITELEM = bits(NUMELEM);
  localparam int BITADDR = bits(NUMFIFO * NUMELEM);
  localparam logic [BITELEM:0] CNT_FULL = (BITELEM+1)'(NUMELEM);
  localparam logic [BITELEM:0] CNT_ONE  = (BITELEM+1)'(1);

  logic [BITDATA-1:0] mem    [NUMFIFO*NUMELEM];
  logic [BITELEM-1:0] head_q [NUMFIFO];
  logic [BITELEM-1:0] head_d [NUMFIFO];
  logic [BITELEM:0]   cnt_q  [NUMFIFO];
  logic [BITELEM:0]   cnt_d  [NUMFIFO];

  logic               ready_q;
  logic               pu_err_q;
  logic               po_err_q;
  logic               rd_vld_q;
  logic [BITDATA-1:0] rd_data_q;
  logic [NUMFIFO-1:0] empty_q;
  logic [NUMFIFO-1:0] empty_d;
  logic [NUMFIFO-1:0] full_q;
  logic [NUMFIFO-1:0] full_d;

  logic               push_acc;
  logic               pop_acc;
  logic               pu_hit;
  logic               po_hit;
  logic               fl_hit;
  logic [BITADDR-1:0] wr_addr;
  logic [BITADDR-1:0] rd_addr;
  logic [BITDATA:0]   shift_out;

  always_comb begin
    // A full FIFO may still take a push when the same cycle pops from it
    pop_acc  = ready_q && pop && (cnt_q[po_prt] != '0) && !(flush && (fl_prt == po_prt));
    push_acc = ready_q && push && !(flush && (fl_prt == pu_prt)) &&
               ((cnt_q[pu_prt] < CNT_FULL) || (pop_acc && (po_prt == pu_prt)));
    wr_addr  = BITADDR'(int'(pu_prt) * NUMELEM +
                        wrap_add(int'(head_q[pu_prt]), int'(cnt_q[pu_prt]), NUMELEM));
    rd_addr  = BITADDR'(int'(po_prt) * NUMELEM + int'(head_q[po_prt]));
    pu_hit   = 1'b0;
    po_hit   = 1'b0;
    fl_hit   = 1'b0;
    empty_d  = '0;
    full_d   = '0;
    for (int i = 0; i < NUMFIFO; i++) begin
      head_d[i] = head_q[i];
      cnt_d[i]  = cnt_q[i];
      pu_hit    = push_acc && (pu_prt == BITFIFO'(i));
      po_hit    = pop_acc && (po_prt == BITFIFO'(i));
      fl_hit    = ready_q && flush && (fl_prt == BITFIFO'(i));
      if (fl_hit) begin
        cnt_d[i] = '0;
      end else if (pu_hit && !po_hit) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (po_hit && !pu_hit) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      if (po_hit) head_d[i] = BITELEM'(wrap_inc(int'(head_q[i]), NUMELEM));
      empty_d[i] = (cnt_d[i] == '0);
      full_d[i]  = (cnt_d[i] == CNT_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      pu_err_q  <= 1'b0;
      po_err_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      empty_q   <= '1;
      full_q    <= '0;
      for (int i = 0; i < NUMFIFO; i++) begin
        head_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      ready_q  <= 1'b1;
      pu_err_q <= ready_q && push && !push_acc;
      po_err_q <= ready_q && pop && !pop_acc;
      rd_vld_q <= pop_acc;
      if (pop_acc) rd_data_q <= mem[rd_addr];
      empty_q  <= empty_d;
      full_q   <= full_d;
      for (int i = 0; i < NUMFIFO; i++) begin
        head_q[i] <= head_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Read above samples the old word when push and pop hit the same slot
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_addr] <= pu_din;
  end

  shift #(
    .WIDTH (BITDATA + 1),
    .DELAY (DAT_DELAY - 1)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .din_i  ({rd_vld_q, rd_data_q}),
    .dout_o (shift_out)
  );

  assign ready   = ready_q;
  assign pu_err  = pu_err_q;
  assign po_err  = po_err_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign po_vld  = shift_out[BITDATA];
  assign po_dout = shift_out[BITDATA-1:0];

endmodule
